xillybus_rd_stream_fifo: RTL and testbench
==========================================

// Module: xillybus_rd_stream_fifo
// PURPOSE
//  Buffers a producer sample stream and drives the Xillybus host-read user port (user_r_rd_*) of the PCIe core wrapper.
//  Sits directly upstream of xillybus; clocked by its bus_clk output.
//  Standard-FIFO read semantics; end-of-stream signalled via user_r_rd_eof; flushed when the host closes the device file.
// PARAMETERS
//  DATA_W  32  sample / user_r_rd_data width; must equal the core's 32-bit read port
//  ADDR_W  9   log2 FIFO depth (DEPTH = 2**ADDR_W = 512 words)
// PORTS
//  bus_clk              in   1         sole clock (xillybus bus_clk)
//  reset                in   1         asynchronous, active-high reset
//  prod_valid           in   1         producer word offered
//  prod_data            in   DATA_W    producer word
//  prod_last            in   1         with prod_valid: this word ends the stream
//  prod_ready           out  1         word accepted (or discarded, see below) when prod_valid & prod_ready
//  user_r_rd_rden       in   1         core read strobe
//  user_r_rd_data       out  DATA_W    read word, valid the cycle after an effective rden
//  user_r_rd_empty      out  1         FIFO holds no words
//  user_r_rd_eof        out  1         end of stream reached; asserted only together with empty
//  user_r_rd_open       in   1         host has the device file open
//  level                out  ADDR_W+1  current word count, 0..DEPTH
//  drop_cnt             out  16        saturating count of discarded producer words
// BEHAVIOUR
//  Single clock domain. One clock and one reset: the reset is asynchronous and active-high.
//  Reset values: count/pointers 0, user_r_rd_empty=1, user_r_rd_eof=0, user_r_rd_data=0, level=0, drop_cnt=0, eof_pending=0, open_q=0.
//  prod_ready = ~full when open & ~eof_pending; otherwise 1, and offered words are discarded.
//  Each discarded word increments drop_cnt, which saturates at 16'hFFFF.
//  Write: prod_valid & prod_ready & open & ~eof_pending -> RAM[wr_ptr] <= prod_data; wr_ptr++ (wraps mod DEPTH).
//  Write with prod_last: word stored; eof_pending <= 1 on the same edge.
//  Read: rden & ~empty -> user_r_rd_data <= RAM[rd_ptr] at the next edge (1-cycle latency); rd_ptr++ (wraps).
//  Read with rden & empty: ignored; pointers unchanged; user_r_rd_data holds its value.
//  Simultaneous effective read + write: count unchanged.
//  At full, prod_ready=0 and the word waits; nothing is lost.
//  empty = (count==0) and full = (count==DEPTH), both from the registered count; level = count.
//  user_r_rd_eof = eof_pending & empty, combinational from registers.
//  Open tracking: open_q <= user_r_rd_open.
//   Close (open_q=1, open=0): flush on the next edge. Pointers and count go to 0 and eof_pending to 0; user_r_rd_data holds.
//   A read or write in the flush cycle is overridden by the flush.
//   Open (open_q=0, open=1): drop_cnt cleared.
//  Mid-stream reset: immediate asynchronous return to reset values; RAM contents are don't-care.
//  States are implicit (EMPTY / FILLING / FULL / DRAINING_EOF / CLOSED) and follow from count, eof_pending and open; no explicit FSM register.
// STRUCTURE
//  Shared package / header: DATA_W default, XB_DROP_CNT_W=16.
//  Sub-module xb_sdp_ram: simple dual-port RAM, one write port, one registered read port (DEPTH x DATA_W).
//  It is inferred as block RAM; its read register drives user_r_rd_data.
//  Top level holds the pointers, count, eof_pending, open_q, drop_cnt and handshake logic.
// TESTING
//  1. Reset, open=1, write 32'h1..32'h4, then rden four single cycles -> data 1,2,3,4 each one cycle after rden; empty=1 after the 4th read; level 4->0.
//  2. Write 512 words -> level=512, prod_ready=0. The 513th word is held until one rden, then accepted; no drop_cnt change.
//  3. Write 3 words, the third with prod_last; read all three -> eof=0 while level>0, eof=1 together with empty=1. A further write is discarded and drop_cnt=1.
//  4. With 100 words buffered, drop open to 0 -> next cycle level=0, empty=1, eof=0; words written while closed go to drop_cnt. Re-open -> drop_cnt=0.
//  5. With 5 words buffered, issue rden and prod_valid in the same cycle -> level stays 5; order preserved across pointer wrap.
//     Also check wrap at 511->0 after 600 total words.
//  6. With empty=1, pulse rden -> data unchanged, pointers unchanged. Assert reset mid-burst -> all outputs at reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/xillybus_rd_stream_fifo_pkg.sv
// Shared constants and helpers for the Xillybus host-read stream FIFO.
package xillybus_rd_stream_fifo_pkg;

    localparam int unsigned XB_DATA_W     = 32;
    localparam int unsigned XB_ADDR_W     = 9;
    localparam int unsigned XB_DROP_CNT_W = 16;

    // Saturating increment for the discarded-word counter.
    function automatic logic [XB_DROP_CNT_W-1:0] sat_inc(input logic [XB_DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/xb_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with an output register that
// holds its value when not reading.
module xb_sdp_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/xillybus_rd_stream_fifo.sv
// Producer-to-host stream FIFO driving the Xillybus user_r_rd_* port, with end-of-stream
// marking, flush on device close and a saturating count of discarded producer words.
module xillybus_rd_stream_fifo
    import xillybus_rd_stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = XB_DATA_W,
    parameter int unsigned ADDR_W = XB_ADDR_W
) (
    input  logic                     bus_clk,
    input  logic                     reset,
    input  logic                     prod_valid,
    input  logic [DATA_W-1:0]        prod_data,
    input  logic                     prod_last,
    output logic                     prod_ready,
    input  logic                     user_r_rd_rden,
    output logic [DATA_W-1:0]        user_r_rd_data,
    output logic                     user_r_rd_empty,
    output logic                     user_r_rd_eof,
    input  logic                     user_r_rd_open,
    output logic [ADDR_W:0]          level,
    output logic [XB_DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0]        wr_ptr_d, wr_ptr_q;
    logic [ADDR_W-1:0]        rd_ptr_d, rd_ptr_q;
    logic [ADDR_W:0]          count_d, count_q;
    logic                     eof_pending_d, eof_pending_q;
    logic                     open_q;
    logic [XB_DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;

    logic empty, full, accepting, flush, open_rise;
    logic wr_en, rd_en, drop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign flush     = open_q & ~user_r_rd_open;
    assign open_rise = ~open_q & user_r_rd_open;
    // Closed device or pending end-of-stream: keep the producer moving and discard its words.
    assign accepting = user_r_rd_open & ~eof_pending_q;
    assign wr_en     = prod_valid & accepting & ~full;
    assign drop      = prod_valid & ~accepting;
    assign rd_en     = user_r_rd_rden & ~empty & ~flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        eof_pending_d = eof_pending_q;
        drop_cnt_d    = drop_cnt_q;
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            eof_pending_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + 1'b1;
            end else if (!wr_en && rd_en) begin
                count_d = count_q - 1'b1;
            end
            if (wr_en && prod_last) begin
                eof_pending_d = 1'b1;
            end
        end
        if (open_rise) begin
            drop_cnt_d = '0;
        end else if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            eof_pending_q <= 1'b0;
            open_q        <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            eof_pending_q <= eof_pending_d;
            open_q        <= user_r_rd_open;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    xb_sdp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (bus_clk),
        .rst  (reset),
        .we   (wr_en),
        .waddr(wr_ptr_q),
        .wdata(prod_data),
        .re   (rd_en),
        .raddr(rd_ptr_q),
        .rdata(user_r_rd_data)
    );

    assign prod_ready      = accepting ? ~full : 1'b1;
    assign user_r_rd_empty = empty;
    assign user_r_rd_eof   = eof_pending_q & empty;
    assign level           = count_q;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_xillybus_rd_stream_fifo.sv
// Self-checking bench for xillybus_rd_stream_fifo against a queue-based reference model.
module tb_xillybus_rd_stream_fifo;

    logic        bus_clk = 1'b0;
    logic        reset;
    logic        prod_valid;
    logic [31:0] prod_data;
    logic        prod_last;
    logic        prod_ready;
    logic        user_r_rd_rden;
    logic [31:0] user_r_rd_data;
    logic        user_r_rd_empty;
    logic        user_r_rd_eof;
    logic        user_r_rd_open;
    logic [9:0]  level;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] m_data;
    bit          m_eof;
    bit          m_open_q;
    int          m_drop;

    always #5 bus_clk = ~bus_clk;

    xillybus_rd_stream_fifo dut (
        .bus_clk        (bus_clk),
        .reset          (reset),
        .prod_valid     (prod_valid),
        .prod_data      (prod_data),
        .prod_last      (prod_last),
        .prod_ready     (prod_ready),
        .user_r_rd_rden (user_r_rd_rden),
        .user_r_rd_data (user_r_rd_data),
        .user_r_rd_empty(user_r_rd_empty),
        .user_r_rd_eof  (user_r_rd_eof),
        .user_r_rd_open (user_r_rd_open),
        .level          (level),
        .drop_cnt       (drop_cnt)
    );

    task automatic model_reset();
        m_q.delete();
        m_data   = '0;
        m_eof    = 0;
        m_open_q = 0;
        m_drop   = 0;
    endtask

    function automatic bit exp_ready();
        if (user_r_rd_open && !m_eof) return m_q.size() != 512;
        return 1'b1;
    endfunction

    // Advance the model by one clock using the current inputs, then step past the edge.
    task automatic tick();
        bit flush, acc, full;
        flush = m_open_q && !user_r_rd_open;
        acc   = user_r_rd_open && !m_eof;
        full  = (m_q.size() == 512);
        if (flush) begin
            m_q.delete();
            m_eof = 0;
        end else begin
            if (user_r_rd_rden && m_q.size() > 0) m_data = m_q.pop_front();
            if (prod_valid && acc && !full) begin
                m_q.push_back(prod_data);
                if (prod_last) m_eof = 1;
            end
        end
        if (!m_open_q && user_r_rd_open) m_drop = 0;
        else if (prod_valid && !acc && m_drop < 65535) m_drop++;
        m_open_q = user_r_rd_open;
        @(posedge bus_clk);
        #1;
    endtask

    task automatic idle_inputs();
        prod_valid     = 0;
        prod_data      = '0;
        prod_last      = 0;
        user_r_rd_rden = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        user_r_rd_open = 0;
        reset = 1;
        model_reset();
        @(posedge bus_clk);
        @(posedge bus_clk);
        #1;
        vectors++;
        if (level !== 10'd0 || user_r_rd_empty !== 1'b1 || user_r_rd_eof !== 1'b0 ||
            user_r_rd_data !== 32'd0 || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset: level=%0d empty=%b eof=%b data=%h drop=%0d, want 0 1 0 0 0",
                     level, user_r_rd_empty, user_r_rd_eof, user_r_rd_data, drop_cnt);
        end
        reset = 0;
        user_r_rd_open = 1;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) begin
            prod_valid = 1;
            prod_data  = 32'(i);
            tick();
        end
        prod_valid = 0;
        vectors++;
        if (level !== 10'd4) begin
            miscompares++;
            $display("FAIL basic_level: got %0d want 4", level);
        end
        for (int i = 1; i <= 4; i++) begin
            user_r_rd_rden = 1;
            tick();
            user_r_rd_rden = 0;
            vectors++;
            if (user_r_rd_data !== 32'(i) || level !== 10'(4 - i)) begin
                miscompares++;
                $display("FAIL basic_read%0d: data=%h level=%0d want %h %0d",
                         i, user_r_rd_data, level, i, 4 - i);
            end
        end
        vectors++;
        if (user_r_rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_empty: got %b want 1", user_r_rd_empty);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 512; i++) begin
            prod_valid = 1;
            prod_data  = 32'h1000 + 32'(i);
            tick();
        end
        prod_data = 32'hABCD_0513;
        repeat (2) begin
            vectors++;
            if (level !== 10'd512 || prod_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL full_hold: level=%0d ready=%b want 512 0", level, prod_ready);
            end
            tick();
        end
        user_r_rd_rden = 1;
        tick();
        user_r_rd_rden = 0;
        vectors++;
        if (level !== 10'd511 || prod_ready !== 1'b1 || user_r_rd_data !== 32'h1000) begin
            miscompares++;
            $display("FAIL full_pop: level=%0d ready=%b data=%h want 511 1 00001000",
                     level, prod_ready, user_r_rd_data);
        end
        tick();
        prod_valid = 0;
        vectors++;
        if (level !== 10'd512 || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL full_accept: level=%0d drop=%0d want 512 0", level, drop_cnt);
        end
        user_r_rd_rden = 1;
        for (int i = 0; i < 512; i++) begin
            tick();
            vectors++;
            if (user_r_rd_data !== m_data) begin
                miscompares++;
                $display("FAIL full_drain%0d: data=%h want %h", i, user_r_rd_data, m_data);
            end
        end
        user_r_rd_rden = 0;
        vectors++;
        if (user_r_rd_data !== 32'hABCD_0513 || user_r_rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL full_last: data=%h empty=%b want abcd0513 1",
                     user_r_rd_data, user_r_rd_empty);
        end
    endtask

    task automatic test_eof();
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1;
            prod_data  = 32'h2000 + 32'(i);
            prod_last  = (i == 2);
            tick();
        end
        prod_valid = 0;
        prod_last  = 0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (user_r_rd_eof !== 1'b0) begin
                miscompares++;
                $display("FAIL eof_early%0d: got %b want 0 (level %0d)", i, user_r_rd_eof, level);
            end
            user_r_rd_rden = 1;
            tick();
            user_r_rd_rden = 0;
        end
        vectors++;
        if (user_r_rd_eof !== 1'b1 || user_r_rd_empty !== 1'b1 || user_r_rd_data !== 32'h2002) begin
            miscompares++;
            $display("FAIL eof_set: eof=%b empty=%b data=%h want 1 1 00002002",
                     user_r_rd_eof, user_r_rd_empty, user_r_rd_data);
        end
        prod_valid = 1;
        prod_data  = 32'h2003;
        vectors++;
        if (prod_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL eof_ready: got %b want 1", prod_ready);
        end
        tick();
        prod_valid = 0;
        vectors++;
        if (drop_cnt !== 16'd1 || level !== 10'd0) begin
            miscompares++;
            $display("FAIL eof_drop: drop=%0d level=%0d want 1 0", drop_cnt, level);
        end
    endtask

    task automatic test_close();
        user_r_rd_open = 0;
        tick();
        user_r_rd_open = 1;
        tick();
        vectors++;
        if (drop_cnt !== 16'd0 || user_r_rd_eof !== 1'b0) begin
            miscompares++;
            $display("FAIL close_prep: drop=%0d eof=%b want 0 0", drop_cnt, user_r_rd_eof);
        end
        for (int i = 0; i < 100; i++) begin
            prod_valid = 1;
            prod_data  = $urandom;
            tick();
        end
        prod_valid = 0;
        user_r_rd_open = 0;
        tick();
        vectors++;
        if (level !== 10'd0 || user_r_rd_empty !== 1'b1 || user_r_rd_eof !== 1'b0 ||
            user_r_rd_data !== m_data) begin
            miscompares++;
            $display("FAIL close_flush: level=%0d empty=%b eof=%b data=%h want 0 1 0 %h",
                     level, user_r_rd_empty, user_r_rd_eof, user_r_rd_data, m_data);
        end
        prod_valid = 1;
        repeat (3) tick();
        prod_valid = 0;
        vectors++;
        if (drop_cnt !== 16'd3 || level !== 10'd0) begin
            miscompares++;
            $display("FAIL close_drop: drop=%0d level=%0d want 3 0", drop_cnt, level);
        end
        user_r_rd_open = 1;
        tick();
        vectors++;
        if (drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reopen_clear: drop=%0d want 0", drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            prod_valid = 1;
            prod_data  = $urandom;
            tick();
        end
        user_r_rd_rden = 1;
        for (int i = 0; i < 600; i++) begin
            prod_data = $urandom;
            tick();
            vectors++;
            if (level !== 10'd5 || user_r_rd_data !== m_data) begin
                miscompares++;
                $display("FAIL b2b%0d: level=%0d data=%h want 5 %h", i, level, user_r_rd_data, m_data);
            end
        end
        prod_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (user_r_rd_data !== m_data) begin
                miscompares++;
                $display("FAIL b2b_drain%0d: data=%h want %h", i, user_r_rd_data, m_data);
            end
        end
        user_r_rd_rden = 0;
    endtask

    task automatic test_empty_read_and_reset();
        user_r_rd_rden = 1;
        tick();
        user_r_rd_rden = 0;
        vectors++;
        if (user_r_rd_data !== m_data || level !== 10'd0 || user_r_rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_read: data=%h level=%0d empty=%b want %h 0 1",
                     user_r_rd_data, level, user_r_rd_empty, m_data);
        end
        // Writes must still land in order after the ignored read.
        prod_valid = 1;
        prod_data  = 32'h3000;
        tick();
        prod_data  = 32'h3001;
        user_r_rd_rden = 1;
        tick();
        vectors++;
        if (user_r_rd_data !== 32'h3000) begin
            miscompares++;
            $display("FAIL empty_after: data=%h want 00003000", user_r_rd_data);
        end
        prod_data = 32'h3002;
        repeat (4) tick();
        #2;
        reset = 1;
        #1;
        vectors++;
        if (level !== 10'd0 || user_r_rd_empty !== 1'b1 || user_r_rd_eof !== 1'b0 ||
            user_r_rd_data !== 32'd0 || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: level=%0d empty=%b eof=%b data=%h drop=%0d want 0 1 0 0 0",
                     level, user_r_rd_empty, user_r_rd_eof, user_r_rd_data, drop_cnt);
        end
        idle_inputs();
        model_reset();
        @(posedge bus_clk);
        #3;
        reset = 0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            prod_valid     = ($urandom_range(0, 3) != 0);
            prod_data      = $urandom;
            prod_last      = ($urandom_range(0, 99) == 0);
            user_r_rd_rden = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 149) == 0) user_r_rd_open = ~user_r_rd_open;
            vectors++;
            if (prod_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rnd_ready%0d: got %b want %b", i, prod_ready, exp_ready());
            end
            tick();
            vectors++;
            if (level !== 10'(m_q.size()) || user_r_rd_empty !== (m_q.size() == 0) ||
                user_r_rd_eof !== (m_eof && m_q.size() == 0) || user_r_rd_data !== m_data ||
                drop_cnt !== 16'(m_drop)) begin
                miscompares++;
                $display("FAIL rnd%0d: level=%0d empty=%b eof=%b data=%h drop=%0d want %0d %b %b %h %0d",
                         i, level, user_r_rd_empty, user_r_rd_eof, user_r_rd_data, drop_cnt,
                         m_q.size(), m_q.size() == 0, m_eof && m_q.size() == 0, m_data, m_drop);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_eof();
        test_close();
        test_back_to_back();
        test_empty_read_and_reset();
        user_r_rd_open = 1;
        tick();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
